// File: rtl/pwm_pkg.sv
// pwm_pkg: shared duty widths, default frequencies and the compare-value helper
package pwm_pkg;
   localparam int DUTY_W       = 4;
   localparam int DUTY_STEPS   = 16;
   localparam int DEF_PWM_FREQ = 1_000;
   localparam int DEF_CLK_FREQ = 200_000_000;
   function automatic longint pwm_cmp(input logic [DUTY_W-1:0] duty, input longint thresh);
      return (longint'(duty) * thresh) >> DUTY_W;
   endfunction
endpackage

// File: rtl/pwm_counter.sv
// pwm_counter: free-running 0..CNT_THRESH-1 period counter with an end-of-period strobe
module pwm_counter #(
   parameter  int CNT_THRESH = 200_000,
   localparam int CNT_WIDTH  = $clog2(CNT_THRESH)
) (
   input  logic                 clk,
   input  logic                 arst,
   output logic [CNT_WIDTH-1:0] cnt,
   output logic                 wrap
);
   assign wrap = cnt == CNT_WIDTH'(CNT_THRESH - 1);
   always_ff @(posedge clk or posedge arst)
      if (arst) cnt <= '0;
      else      cnt <= wrap ? '0 : cnt + CNT_WIDTH'(1);
endmodule

// File: rtl/pwm.sv
// pwm: static-duty PWM; the duty is shadowed at each period boundary so pulses are never truncated
module pwm
   import pwm_pkg::*;
#(
   parameter  int PWM_FREQ   = DEF_PWM_FREQ,
   parameter  int CLK_FREQ   = DEF_CLK_FREQ,
   localparam int CNT_THRESH = CLK_FREQ / (PWM_FREQ > 0 ? PWM_FREQ : 1),
   localparam int CNT_WIDTH  = $clog2(CNT_THRESH)
) (
   input  logic              clk,
   input  logic              arst,
   input  logic [DUTY_W-1:0] duty_cycle,
   output logic              pwm_en
);
   logic [CNT_WIDTH-1:0]        cnt;
   logic                        wrap;
   logic [DUTY_W-1:0]           duty_q;
   logic [CNT_WIDTH+DUTY_W-1:0] cmp;
   if (PWM_FREQ <= 0) begin : g_bad_pwm_freq
      $fatal(1, "pwm: PWM_FREQ must be positive");
   end else if (CLK_FREQ < DUTY_STEPS * PWM_FREQ) begin : g_bad_ratio
      $fatal(1, "pwm: CLK_FREQ must be at least 16*PWM_FREQ");
   end else if (CLK_FREQ % PWM_FREQ != 0) begin : g_trunc
      $warning("pwm: CLK_FREQ/PWM_FREQ is not an integer, period truncated");
   end
   pwm_counter #(.CNT_THRESH(CNT_THRESH)) u_cnt (
      .clk  (clk),
      .arst (arst),
      .cnt  (cnt),
      .wrap (wrap)
   );
   assign cmp = (CNT_WIDTH+DUTY_W)'(pwm_cmp(duty_q, longint'(CNT_THRESH)));
   // duty_q only moves on wrap, so cmp is stable for the whole period
   always_ff @(posedge clk or posedge arst)
      if (arst) begin
         duty_q <= '0;
         pwm_en <= 1'b0;
      end else begin
         if (wrap) duty_q <= duty_cycle;
         pwm_en <= {{DUTY_W{1'b0}}, cnt} < cmp;
      end
endmodule

// File: tb/tb_pwm.sv
// tb_pwm: per-period high-time scoreboard for pwm at a reduced 160-cycle period
module tb_pwm;
   localparam int CLK_F = 1600;
   localparam int PWM_F = 10;
   localparam int T     = CLK_F / PWM_F;
   typedef struct {
      logic [3:0] duty;
      int         exp_high;
   } vec_t;
   logic       clk = 1'b0;
   logic       arst = 1'b1;
   logic [3:0] duty_cycle = 4'd5;
   logic       pwm_en;
   int         n_checks = 0;
   int         n_fail = 0;
   int         n = 0;
   int         hi = 0;
   int         lead = 0;
   int         idx = 0;
   int         e = 0;
   int         nxt = 0;
   bit         mon_on = 1'b0;
   int         exp_q[$];
   vec_t       vecs[$];

   pwm #(.PWM_FREQ(PWM_F), .CLK_FREQ(CLK_F)) dut (
      .clk        (clk),
      .arst       (arst),
      .duty_cycle (duty_cycle),
      .pwm_en     (pwm_en)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic to_cycle(input int k);
      while (n < k) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic set_at(input int k, input int d, input int exp);
      to_cycle(k);
      duty_cycle = 4'(d);
      if (exp >= 0) exp_q.push_back(exp);
   endtask

   task automatic release_rst();
      @(negedge clk);
      #1;
      arst = 1'b0;
      mon_on = 1'b1;
      exp_q.push_back(0);
   endtask

   // n counts negedges since release; the sample after edge n shows the compare of cnt=(n-1)%T
   always @(negedge clk) begin
      if (!mon_on) n = 0;
      else begin
         n++;
         idx = (n - 1) % T;
         if (idx == 0) begin
            hi = 0;
            lead = 0;
         end
         if (pwm_en === 1'b1) begin
            if (lead == idx) lead++;
            hi++;
         end
         if (idx == T - 1) begin
            e = exp_q.size() > 0 ? exp_q.pop_front() : -1;
            check($sformatf("period%0d_high", (n - 1) / T), lead == hi ? hi : -1, e);
         end
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 3; i++) vecs.push_back('{4'd0, 0});
      for (int i = 0; i < 2; i++) vecs.push_back('{4'd8, 80});
      for (int d = 1; d < 16; d++)
         for (int r = 0; r < 2; r++) vecs.push_back('{4'(d), d * T / 16});
      repeat (3) begin
         @(negedge clk);
         check("rst_pwm_en", int'(pwm_en), 0);
         check("rst_cnt", int'(dut.u_cnt.cnt), 0);
      end
      release_rst();
      nxt = 0;
      foreach (vecs[i]) begin
         set_at(nxt, int'(vecs[i].duty), vecs[i].exp_high);
         nxt += T;
      end
      set_at(nxt, 3, 30);
      set_at(nxt + T + 40, 12, 120);
      nxt += 2 * T;
      set_at(nxt, 4, -1);
      set_at(nxt + T - 1, 9, 90);
      set_at(nxt + T, 2, 20);
      nxt += 2 * T;
      set_at(nxt, 12, 120);
      to_cycle(nxt + T + 20);
      mon_on = 1'b0;
      check("pre_rst_high", int'(pwm_en), 1);
      arst = 1'b1;
      #1;
      check("async_drop", int'(pwm_en), 0);
      check("mid_rst_cnt", int'(dut.u_cnt.cnt), 0);
      check("mid_rst_duty_q", int'(dut.duty_q), 0);
      exp_q.delete();
      duty_cycle = 4'd6;
      repeat (3) @(negedge clk);
      release_rst();
      to_cycle(1);
      check("cnt_restart", int'(dut.u_cnt.cnt), 1);
      set_at(T - 1, 6, 60);
      set_at(T, 7, 70);
      to_cycle(3 * T);
      check("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
